multu_hilo_unit: RTL and testbench
==================================

Name: multu_hilo_unit

Overview:
- Consumer end of the ALU-control operation bus. It receives the 6-bit operation code that the ALU control unit drives to the multiplier (SignaltoMut).
- Performs unsigned 32x32 multiply with a radix-2 shift-add sequencer, one step per cycle while the code is MULTU.
- Writes the 64-bit product into HI/LO only when the control unit issues the HiLo-open code (6'b111111).
- Serves mfhi/mflo reads to the writeback MUX.

Parameters:
- WIDTH, 32, operand width; product is 2*WIDTH.
- OP_MULTU, 6'd25, one multiply step.
- OP_MFHI, 6'd16, read HI.
- OP_MFLO, 6'd18, read LO.
- OP_OPEN_HILO, 6'b111111, commit product to HI/LO.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- op  in  6  operation code from the ALU control unit.
- dataA  in  WIDTH  multiplicand (rs).
- dataB  in  WIDTH  multiplier (rt).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rdata  out  WIDTH  op==OP_MFHI -> hi; op==OP_MFLO -> lo; else 0. Combinational from registered hi/lo.
- busy  out  1  high in RUN or READY.
- done  out  1  one-cycle pulse the cycle after a successful commit.
- err  out  1  one-cycle pulse the cycle after a commit attempt while the product is incomplete.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, step count=0, product=0, mcand=0, hi=0, lo=0, done=0, err=0; busy=0.
- States: IDLE, RUN, READY.
- IDLE:
  - op==OP_MULTU: latch mcand=dataA, product={0,dataB}, perform step 1 in the same edge, step count=1, go to RUN.
  - op==OP_OPEN_HILO: err pulse; hi/lo unchanged.
  - Any other op: no change.
- Step (unsigned), using a WIDTH+1-bit upper accumulator for carry:
  - If product[0]=1, upper += mcand.
  - Then shift {carry,upper,lower} right by 1.
- RUN:
  - op==OP_MULTU: next step, step count+1; when the count reaches WIDTH, go to READY.
  - op==OP_OPEN_HILO: abort. err pulse, hi/lo unchanged, go to IDLE.
  - Any other op: hold (pause). Operands and step count are frozen, and the run resumes on the next OP_MULTU.
- READY:
  - op==OP_MULTU: hold; no further steps, product stable.
  - op==OP_OPEN_HILO: hi=product[2W-1:W], lo=product[W-1:0], done pulse, go to IDLE.
  - Any other op: hold.
- dataA/dataB are sampled only on the IDLE->RUN edge; later changes are ignored.
- Latency: first OP_MULTU to READY is exactly WIDTH OP_MULTU cycles. Commit is visible on hi/lo and rdata the cycle after OP_OPEN_HILO.
- Read during commit cycle: mfhi/mflo in the same cycle as a commit returns the old value (cannot occur with a single op bus, but rdata is defined purely from current hi/lo).
- Back-to-back: an OP_MULTU in the cycle after a commit starts a new multiply from IDLE.
- Reset mid-operation: all state is cleared immediately and the partial product is discarded.
- X on op is treated as "other op" (hold); no X may propagate to hi/lo.

Decomposition:
- Shared package alu_ops_pkg holds:
  - function-code constants F_add, F_sub, F_or, F_slt, F_andi, F_multu, F_mfhi, F_mflo and OP_OPEN_HILO;
  - ALUOp encodings;
  - the state enum for this unit.
- The ALU control unit imports the same package.
- One sub-module, multu_step_dp, is natural: a combinational single shift-add step taking (product, mcand) and returning the next product. The top module keeps the FSM, counter and HI/LO registers.

Test Plan:
1. dataA=7, dataB=9; 32 cycles OP_MULTU, then OP_OPEN_HILO -> hi=0, lo=63, done pulses once, busy falls; then OP_MFLO -> rdata=63.
2. dataA=dataB=32'hFFFFFFFF; full sequence -> hi=32'hFFFFFFFE, lo=32'h00000001 (carry-path check).
3. Preload hi/lo via test 1; start a new multu (dataA=3, dataB=5); OP_OPEN_HILO after 10 steps -> err pulse, hi=0, lo=63 unchanged, state IDLE.
4. dataA=32'h12345678, dataB=32'h9ABCDEF0; insert 5 cycles of op=F_add after step 16, change dataA meanwhile -> final hi:lo=64'h0B00EA4E_242D2080 (dataA change ignored).
5. rst_n low at step 20 of a multu, asynchronous to clk -> busy/hi/lo/rdata=0 immediately; a later full sequence with 2*3 yields lo=6.
6. 40 cycles OP_MULTU (8 extra in READY) with dataA=dataB=65536 -> commit gives hi=1, lo=0; product unchanged by the extra cycles.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// Operation codes shared by the ALU control unit and the multiplier,
// plus the sequencing states of the HI/LO multiply unit.
package alu_ops_pkg;

  // Function codes driven onto the ALU-control operation bus.
  localparam logic [5:0] F_add   = 6'd32;
  localparam logic [5:0] F_sub   = 6'd34;
  localparam logic [5:0] F_or    = 6'd37;
  localparam logic [5:0] F_slt   = 6'd42;
  localparam logic [5:0] F_andi  = 6'd12;
  localparam logic [5:0] F_multu = 6'd25;
  localparam logic [5:0] F_mfhi  = 6'd16;
  localparam logic [5:0] F_mflo  = 6'd18;

  localparam logic [5:0] OP_MULTU     = F_multu;
  localparam logic [5:0] OP_MFHI      = F_mfhi;
  localparam logic [5:0] OP_MFLO      = F_mflo;
  localparam logic [5:0] OP_OPEN_HILO = 6'b111111;

  // ALUOp encodings from the main decoder to the ALU control unit.
  typedef enum logic [1:0] {
    ALUOP_MEM   = 2'b00,
    ALUOP_BEQ   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_ANDI  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_READY = 2'b10
  } multu_state_e;

endpackage

// File: rtl/multu_step_dp.sv
// One radix-2 unsigned shift-add step: conditionally add the multiplicand
// into the upper half (with a carry bit), then shift the whole product right.
module multu_step_dp #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_product,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic [2*WIDTH-1:0] o_product
);

  logic [WIDTH:0] w_addend;
  logic [WIDTH:0] w_upper;

  assign w_addend  = i_product[0] ? {1'b0, i_mcand} : {(WIDTH+1){1'b0}};
  assign w_upper   = {1'b0, i_product[2*WIDTH-1:WIDTH]} + w_addend;
  // The carry lands in the MSB after the shift; the consumed LSB drops out.
  assign o_product = {w_upper, i_product[WIDTH-1:1]};

endmodule

// File: rtl/multu_hilo_unit.sv
// Unsigned multiplier with HI/LO registers, stepped one bit per OP_MULTU
// cycle and committed to HI/LO only on the HiLo-open code.
module multu_hilo_unit
  import alu_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = $clog2(WIDTH + 1);

  multu_state_e r_state;
  multu_state_e w_state_next;

  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_err;

  logic               w_load;
  logic               w_step;
  logic               w_commit;
  logic               w_fault;
  logic [CW-1:0]      w_count_step;
  logic [2*WIDTH-1:0] w_dp_product;
  logic [WIDTH-1:0]   w_dp_mcand;
  logic [2*WIDTH-1:0] w_dp_next;

  // The first step runs in the same edge that latches the operands.
  assign w_dp_product = (r_state == ST_IDLE) ? {{WIDTH{1'b0}}, dataB} : r_product;
  assign w_dp_mcand   = (r_state == ST_IDLE) ? dataA : r_mcand;
  assign w_count_step = w_load ? CW'(1) : r_count + CW'(1);

  multu_step_dp #(.WIDTH(WIDTH)) u_step (
    .i_product (w_dp_product),
    .i_mcand   (w_dp_mcand),
    .o_product (w_dp_next)
  );

  // An unknown op fails every equality test below and so falls through to hold.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_commit     = 1'b0;
    w_fault      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op == OP_MULTU) begin
          w_load       = 1'b1;
          w_step       = 1'b1;
          w_state_next = (w_count_step == CW'(WIDTH)) ? ST_READY : ST_RUN;
        end else if (op == OP_OPEN_HILO) begin
          w_fault = 1'b1;
        end
      end
      ST_RUN: begin
        if (op == OP_MULTU) begin
          w_step       = 1'b1;
          w_state_next = (w_count_step == CW'(WIDTH)) ? ST_READY : ST_RUN;
        end else if (op == OP_OPEN_HILO) begin
          w_fault      = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      ST_READY: begin
        if (op == OP_OPEN_HILO) begin
          w_commit     = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_product <= '0;
      r_mcand   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_done <= w_commit;
      r_err  <= w_fault;
      if (w_load) begin
        r_mcand <= dataA;
      end
      if (w_step) begin
        r_product <= w_dp_next;
        r_count   <= w_count_step;
      end
      if (w_commit) begin
        r_hi <= r_product[2*WIDTH-1:WIDTH];
        r_lo <= r_product[WIDTH-1:0];
      end
      if (w_commit || w_fault) begin
        r_count <= '0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (op == OP_MFHI) begin
      rdata = r_hi;
    end else if (op == OP_MFLO) begin
      rdata = r_lo;
    end
  end

  assign hi   = r_hi;
  assign lo   = r_lo;
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign err  = r_err;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Self-checking bench for multu_hilo_unit: directed scenarios plus randomized
// multiplies with pauses, checked against an arithmetic reference model.
module tb_multu_hilo_unit;
  import alu_ops_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [5:0]   op;
  logic [W-1:0] dataA, dataB;
  logic [W-1:0] hi, lo, rdata;
  logic         busy, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: operation progress as a step count, product as a*b.
  bit           m_active;
  int           m_steps;
  logic [W-1:0] m_a, m_b, m_hi, m_lo;
  bit           m_done, m_err;

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .op    (op),
    .dataA (dataA),
    .dataB (dataB),
    .hi    (hi),
    .lo    (lo),
    .rdata (rdata),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_steps  = 0;
    m_a      = '0;
    m_b      = '0;
    m_hi     = '0;
    m_lo     = '0;
    m_done   = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge(input logic [5:0] o);
    logic [63:0] prod;
    m_done = 1'b0;
    m_err  = 1'b0;
    if (o === OP_MULTU) begin
      if (!m_active) begin
        m_active = 1'b1;
        m_a      = dataA;
        m_b      = dataB;
        m_steps  = 1;
      end else if (m_steps < W) begin
        m_steps++;
      end
    end else if (o === OP_OPEN_HILO) begin
      if (m_active && m_steps == W) begin
        prod   = 64'(m_a) * 64'(m_b);
        m_hi   = prod[63:32];
        m_lo   = prod[31:0];
        m_done = 1'b1;
      end else begin
        m_err = 1'b1;
      end
      m_active = 1'b0;
      m_steps  = 0;
    end
  endtask

  task automatic step(input logic [5:0] o, input string tag);
    op = o;
    model_edge(o);
    @(posedge clk);
    #1;
    check({tag, ".busy"}, 64'(busy), 64'(m_active));
    check({tag, ".done"}, 64'(done), 64'(m_done));
    check({tag, ".err"},  64'(err),  64'(m_err));
    check({tag, ".hi"},   64'(hi),   64'(m_hi));
    check({tag, ".lo"},   64'(lo),   64'(m_lo));
  endtask

  task automatic run_multu(input logic [W-1:0] a, input logic [W-1:0] b,
                           input int n, input string tag);
    dataA = a;
    dataB = b;
    repeat (n) step(OP_MULTU, tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [5:0]   pop;
    logic [63:0]  exp_prod;
    int           guard;

    rst_n = 1'b0;
    op    = F_add;
    dataA = '0;
    dataB = '0;
    model_reset();
    #12;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.err",  64'(err),  64'd0);
    check("reset.hi",   64'(hi),   64'd0);
    check("reset.lo",   64'(lo),   64'd0);
    op = OP_MFHI;
    #1;
    check("reset.rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 7 * 9
    run_multu(32'd7, 32'd9, 32, "t1");
    step(OP_OPEN_HILO, "t1.commit");
    check("t1.done", 64'(done), 64'd1);
    check("t1.lo",   64'(lo),   64'd63);
    check("t1.hi",   64'(hi),   64'd0);
    step(F_mflo, "t1.mflo");
    check("t1.rdata_lo", 64'(rdata), 64'd63);
    step(F_mfhi, "t1.mfhi");
    check("t1.rdata_hi", 64'(rdata), 64'd0);

    // Abort after 10 steps keeps previous HI/LO.
    run_multu(32'd3, 32'd5, 10, "t3");
    step(OP_OPEN_HILO, "t3.abort");
    check("t3.err",  64'(err),  64'd1);
    check("t3.busy", 64'(busy), 64'd0);
    check("t3.lo",   64'(lo),   64'd63);
    check("t3.hi",   64'(hi),   64'd0);

    // One step short of completion is still an abort.
    run_multu(32'd4, 32'd4, W - 1, "lat");
    step(OP_OPEN_HILO, "lat.commit31");
    check("lat.err", 64'(err), 64'd1);
    check("lat.lo",  64'(lo),  64'd63);

    // All-ones exercises the carry path.
    run_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "t2");
    step(OP_OPEN_HILO, "t2.commit");
    check("t2.hi", 64'(hi), 64'hFFFF_FFFE);
    check("t2.lo", 64'(lo), 64'h0000_0001);

    // Pause mid-run with other ops while the operands change.
    run_multu(32'h1234_5678, 32'h9ABC_DEF0, 16, "t4");
    repeat (5) begin
      dataA = $urandom;
      dataB = $urandom;
      step(F_add, "t4.pause");
    end
    repeat (16) step(OP_MULTU, "t4.resume");
    step(OP_OPEN_HILO, "t4.commit");
    check("t4.hilo", {hi, lo}, 64'h0B00EA4E_242D2080);

    // Asynchronous reset in the middle of a run.
    run_multu(32'd5, 32'd6, 20, "t5");
    op = OP_MFHI;
    #2;
    check("t5.pre_rdata", 64'(rdata), 64'h0B00EA4E);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t5.busy",  64'(busy),  64'd0);
    check("t5.hi",    64'(hi),    64'd0);
    check("t5.lo",    64'(lo),    64'd0);
    check("t5.rdata", 64'(rdata), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_multu(32'd2, 32'd3, 32, "t5b");
    step(OP_OPEN_HILO, "t5b.commit");
    check("t5b.lo", 64'(lo), 64'd6);

    // Extra multu cycles in READY leave the product alone.
    run_multu(32'd65536, 32'd65536, 40, "t6");
    step(OP_OPEN_HILO, "t6.commit");
    check("t6.hi", 64'(hi), 64'd1);
    check("t6.lo", 64'(lo), 64'd0);

    // Randomized multiplies with random pauses, reads and operand churn.
    for (int it = 0; it < 8; it++) begin
      ra = $urandom;
      rb = $urandom;
      exp_prod = 64'(ra) * 64'(rb);
      run_multu(ra, rb, 1, "rnd.start");
      guard = 0;
      while (m_steps < W && guard < 1000) begin
        guard++;
        dataA = $urandom;
        dataB = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 4))
            0:       pop = F_add;
            1:       pop = F_sub;
            2:       pop = OP_MFHI;
            3:       pop = OP_MFLO;
            default: pop = 6'bxxxxxx;
          endcase
          step(pop, "rnd.pause");
          if (pop === OP_MFHI) check("rnd.rdata_hi", 64'(rdata), 64'(m_hi));
          else if (pop === OP_MFLO) check("rnd.rdata_lo", 64'(rdata), 64'(m_lo));
          else check("rnd.rdata_other", 64'(rdata), 64'd0);
        end else begin
          step(OP_MULTU, "rnd.step");
        end
      end
      check("rnd.guard", 64'(m_steps), 64'(W));
      repeat ($urandom_range(0, 3)) step(OP_MULTU, "rnd.ready");
      step(OP_OPEN_HILO, "rnd.commit");
      check("rnd.hilo", {hi, lo}, exp_prod);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
